gnrc_credit_fifo: RTL and testbench

Credit-tracked receive FIFO sitting directly downstream of the gated valid/data delay line. Upstream issue logic asks for a credit before launching a beat into the delay line. The delay line has no backpressure, so every launched beat is guaranteed a slot here on arrival. The block converts the valid-only stream into a valid/ready stream for the consumer, returns credits as entries drain, and flags any protocol-violating arrival.

---
 rtl/gnrc_credit_fifo.sv | 136 +++++++++++++
 tb/tb_gnrc_credit_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gnrc_credit_fifo.sv
// Credit-tracked receive FIFO: turns a valid-only, no-backpressure arrival stream into a
// valid/ready stream and hands out one credit per free slot to the upstream issue logic.
module gnrc_credit_fifo #(
  parameter int  DEPTH = 4,
  parameter type DTYPE = logic,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic          valid_i,
  input  DTYPE          data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output DTYPE          data_o,
  output logic [CW-1:0] credit_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ZERO_P   = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  DTYPE          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_credit;
  logic          r_valid;
  logic          r_overflow;

  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_credit_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_accept;
  logic          w_drop;
  logic          w_gnt;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == LAST_PTR) begin
      r = ZERO_P;
    end else begin
      r = p + ONE_P;
    end
    return r;
  endfunction

  // Handshake decode and next-state arithmetic for pointers, occupancy and credits.
  always_comb begin
    w_full   = (r_count == FULL_CNT);
    w_push   = valid_i & ~flush_i;
    w_pop    = r_valid & ready_i & ~flush_i;
    // A full FIFO still takes the arriving beat when the head leaves in the same cycle.
    w_accept = w_push & (~w_full | w_pop);
    w_drop   = w_push & w_full & ~w_pop;
    w_gnt    = req_i & (r_credit != ZERO_C) & ~flush_i & ~rst_i;

    case ({w_accept, w_pop})
      2'b10:   w_count_nxt = r_count + ONE_C;
      2'b01:   w_count_nxt = r_count - ONE_C;
      default: w_count_nxt = r_count;
    endcase

    case ({w_pop, w_gnt})
      2'b10:   w_credit_nxt = r_credit + ONE_C;
      2'b01:   w_credit_nxt = r_credit - ONE_C;
      default: w_credit_nxt = r_credit;
    endcase

    if (w_accept) begin
      w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  // Control state: reset beats flush, flush clears everything except the sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= ZERO_P;
      r_rd_ptr   <= ZERO_P;
      r_count    <= ZERO_C;
      r_credit   <= FULL_CNT;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr   <= ZERO_P;
      r_rd_ptr   <= ZERO_P;
      r_count    <= ZERO_C;
      r_credit   <= FULL_CNT;
      r_valid    <= 1'b0;
      r_overflow <= r_overflow;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_credit   <= w_credit_nxt;
      r_valid    <= (w_count_nxt != ZERO_C);
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_accept && !rst_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign gnt_o      = w_gnt;
  assign valid_o    = r_valid;
  assign data_o     = r_mem[r_rd_ptr];
  assign credit_o   = r_credit;
  assign count_o    = r_count;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_gnrc_credit_fifo.sv
// Bench for gnrc_credit_fifo: DEPTH=4 against a queue model fed by a 3-stage delay line,
// plus a DEPTH=1 instance driven from a vector table.
module tb_gnrc_credit_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance signals
  logic       rst, flush, req, vin, rdy;
  logic [7:0] din;
  logic       gnt, vout, ovf;
  logic [7:0] dout;
  logic [2:0] credit, count;

  // DEPTH=1 instance signals
  logic       flush1, req1, vin1, rdy1;
  logic [7:0] din1;
  logic       gnt1, vout1, ovf1;
  logic [7:0] dout1;
  logic [0:0] credit1, count1;

  gnrc_credit_fifo #(.DEPTH(4), .DTYPE(logic [7:0])) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req), .gnt_o(gnt),
    .valid_i(vin), .data_i(din), .valid_o(vout), .ready_i(rdy), .data_o(dout),
    .credit_o(credit), .count_o(count), .overflow_o(ovf)
  );

  gnrc_credit_fifo #(.DEPTH(1), .DTYPE(logic [7:0])) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .req_i(req1), .gnt_o(gnt1),
    .valid_i(vin1), .data_i(din1), .valid_o(vout1), .ready_i(rdy1), .data_o(dout1),
    .credit_o(credit1), .count_o(count1), .overflow_o(ovf1)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: stored beats, free credits, sticky error, delay-line contents.
  logic [7:0] m_q[$];
  int         m_credit;
  logic       m_ovf;
  logic       pipe_v[3];
  logic [7:0] pipe_d[3];
  logic [7:0] next_data;
  logic       inj_en, inj_v;
  logic [7:0] inj_d;
  logic       chk_en, inv_en;
  int         gnt_cnt, obs_pops;

  typedef struct {
    logic       req, vin, rdy;
    logic [7:0] din;
    logic       egnt, evalid;
    logic [7:0] edata;
    logic       ecredit, ecount;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One DEPTH=4 clock cycle: present delay-line output, check, clock, advance model.
  task automatic cycle();
    logic eg, ev, pop, gnt_seen;
    int   infl;
    vin = inj_en ? inj_v : pipe_v[2];
    din = inj_en ? inj_d : pipe_d[2];
    #1;
    eg = !rst && !flush && req && (m_credit != 0);
    ev = (m_q.size() != 0);
    gnt_seen = gnt;
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(eg));
      chk("credit", 32'(credit), 32'(m_credit));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("valid", 32'(vout), 32'(ev));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      if (ev) chk("data", 32'(dout), 32'(m_q[0]));
      if (inv_en) begin
        infl = int'(pipe_v[0]) + int'(pipe_v[1]) + int'(pipe_v[2]);
        chk("invariant", 32'(int'(credit) + int'(count) + infl), 32'd4);
      end
    end
    if (gnt === 1'b1) gnt_cnt++;
    if (vout === 1'b1 && rdy && !flush && !rst) obs_pops++;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_credit = 4; m_ovf = 1'b0;
    end else if (flush) begin
      m_q.delete(); m_credit = 4;
    end else begin
      pop = ev && rdy;
      if (pop) void'(m_q.pop_front());
      if (vin) begin
        if (m_q.size() < 4) m_q.push_back(din);
        else m_ovf = 1'b1;
      end
      m_credit = m_credit + (pop ? 1 : 0) - (eg ? 1 : 0);
    end
    if (rst || flush) begin
      for (int k = 0; k < 3; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = 8'h00; end
    end else begin
      pipe_v[2] = pipe_v[1]; pipe_d[2] = pipe_d[1];
      pipe_v[1] = pipe_v[0]; pipe_d[1] = pipe_d[0];
      pipe_v[0] = (gnt_seen === 1'b1); pipe_d[0] = next_data;
      if (gnt_seen === 1'b1) next_data = next_data + 8'h01;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; req = 1'b1; rdy = 1'b0; vin = 1'b0; din = 8'h00;
    flush1 = 1'b0; req1 = 1'b0; vin1 = 1'b0; rdy1 = 1'b0; din1 = 8'h00;
    inj_en = 1'b0; inj_v = 1'b0; inj_d = 8'h00; chk_en = 1'b0; inv_en = 1'b1;
    m_credit = 4; m_ovf = 1'b0; next_data = 8'h0A; gnt_cnt = 0; obs_pops = 0;
    for (int k = 0; k < 3; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = 8'h00; end
    #1;

    // Reset with req held high: no grant, full credits.
    cycle();
    chk_en = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;

    // Fill with ready low: exactly four grants, beats 0xA..0xD stored.
    gnt_cnt = 0;
    repeat (12) cycle();
    chk("fill_grants", 32'(gnt_cnt), 32'd4);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_credit", 32'(credit), 32'd0);

    // Drain in order, credits come home.
    req = 1'b0; rdy = 1'b1;
    repeat (6) cycle();
    chk("drain_credit", 32'(credit), 32'd4);
    chk("drain_count", 32'(count), 32'd0);

    // Streaming across pointer wrap.
    req = 1'b1; rdy = 1'b1; obs_pops = 0;
    repeat (40) cycle();
    chk("stream_pops_gt12", 32'(obs_pops > 12), 32'd1);

    // Fill up, then full+push+pop, then full+push without pop.
    rdy = 1'b0;
    repeat (10) cycle();
    chk("refill_count", 32'(count), 32'd4);
    req = 1'b0; inj_en = 1'b1; inv_en = 1'b0;
    inj_v = 1'b1; inj_d = 8'h50; rdy = 1'b1;
    cycle();
    chk("full_pushpop_count", 32'(count), 32'd4);
    chk("full_pushpop_ovf", 32'(ovf), 32'd0);
    inj_d = 8'h60; rdy = 1'b0;
    cycle();
    inj_v = 1'b0;
    cycle();
    chk("overflow_set", 32'(ovf), 32'd1);
    chk("overflow_count", 32'(count), 32'd4);
    rdy = 1'b1;
    repeat (5) cycle();

    // Restore accounting; flush while a credit is available must not grant.
    rdy = 1'b0; inj_en = 1'b0; flush = 1'b1;
    cycle();
    inv_en = 1'b1; req = 1'b1;
    cycle();
    flush = 1'b0;

    // Flush with two stored and two in flight.
    repeat (5) cycle();
    chk("preflush_count", 32'(count), 32'd2);
    flush = 1'b1; req = 1'b1; rdy = 1'b1;
    cycle();
    flush = 1'b0; req = 1'b0;
    cycle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_credit", 32'(credit), 32'd4);
    chk("flush_valid", 32'(vout), 32'd0);
    chk("flush_keeps_ovf", 32'(ovf), 32'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      req   = 1'($urandom_range(0, 1));
      rdy   = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b1; flush = 1'b0; req = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_clears_ovf", 32'(ovf), 32'd0);

    // DEPTH=1 table: credit toggles between 1 and 0, never overflows.
    for (int i = 0; i < 10; i++) begin
      req1 = tbl[i].req; vin1 = tbl[i].vin; rdy1 = tbl[i].rdy; din1 = tbl[i].din;
      #1;
      chk($sformatf("d1_gnt[%0d]", i), 32'(gnt1), 32'(tbl[i].egnt));
      chk($sformatf("d1_valid[%0d]", i), 32'(vout1), 32'(tbl[i].evalid));
      chk($sformatf("d1_credit[%0d]", i), 32'(credit1), 32'(tbl[i].ecredit));
      chk($sformatf("d1_count[%0d]", i), 32'(count1), 32'(tbl[i].ecount));
      chk($sformatf("d1_ovf[%0d]", i), 32'(ovf1), 32'd0);
      if (tbl[i].evalid) chk($sformatf("d1_data[%0d]", i), 32'(dout1), 32'(tbl[i].edata));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
